// File: rtl/mbinit_param_negotiator.sv
// MBINIT.PARAM exchange: sends local capabilities as PARAM_REQ and resolves them against the partner's PARAM_RSP.
// Optional feature macro: PARAM_NEG_RETRY_EN (re-send the request after a timeout, up to MAX_RETRY times).
module mbinit_param_negotiator #(
    parameter int unsigned TIMEOUT_CYC = 8000,
    parameter int unsigned CNT_W       = 14,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        i_start,
    input  logic [2:0]  i_Max_DataRate,
    input  logic [1:0]  i_Clock_Mode,
    input  logic [1:0]  i_Phase_Clock,
    input  logic [4:0]  i_Voltage_swing,
    output logic        o_tx_valid,
    output logic [1:0]  o_tx_msgid,
    output logic [15:0] o_tx_data,
    input  logic        i_tx_ready,
    input  logic        i_rx_valid,
    input  logic [1:0]  i_rx_msgid,
    input  logic [15:0] i_rx_data,
    output logic [2:0]  o_Neg_DataRate,
    output logic [1:0]  o_Neg_Clock_Mode,
    output logic [1:0]  o_Neg_Phase_Clock,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CAP_W  = 12;
    localparam logic [1:0]  MSG_REQ = 2'b01;
    localparam logic [1:0]  MSG_RSP = 2'b10;

    typedef struct packed {
        logic [4:0] vswing;
        logic [1:0] phase;
        logic [1:0] clk_mode;
        logic [2:0] rate;
    } cap_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_REQ, S_WAIT_RSP, S_RESOLVE, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    cap_t              snap_q, snap_d;
    cap_t              rsp_q, rsp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [1:0]        tx_msgid_q, tx_msgid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [2:0]        neg_rate_q, neg_rate_d;
    logic [1:0]        neg_clk_q, neg_clk_d;
    logic [1:0]        neg_phase_q, neg_phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic       res_fail;
    logic [2:0] res_rate;
    logic [1:0] res_phase;

`ifdef PARAM_NEG_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    // Reserved response bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{i_rx_data[DATA_W-1:CAP_W], 32'(MAX_RETRY)};

    assign res_rate  = (snap_q.rate < rsp_q.rate) ? snap_q.rate : rsp_q.rate;
    assign res_phase = snap_q.phase & rsp_q.phase;
    assign res_fail  = (snap_q.rate == 3'd0) || (rsp_q.rate == 3'd0) ||
                       (snap_q.clk_mode != rsp_q.clk_mode) || (res_phase == 2'b00);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            rsp_q       <= '0;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_msgid_q  <= '0;
            tx_data_q   <= '0;
            neg_rate_q  <= '0;
            neg_clk_q   <= '0;
            neg_phase_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PARAM_NEG_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            rsp_q       <= rsp_d;
            cnt_q       <= cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_msgid_q  <= tx_msgid_d;
            tx_data_q   <= tx_data_d;
            neg_rate_q  <= neg_rate_d;
            neg_clk_q   <= neg_clk_d;
            neg_phase_q <= neg_phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PARAM_NEG_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        neg_rate_d  = neg_rate_q;
        neg_clk_d   = neg_clk_q;
        neg_phase_d = neg_phase_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef PARAM_NEG_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    snap_d.rate     = i_Max_DataRate;
                    snap_d.clk_mode = i_Clock_Mode;
                    snap_d.phase    = i_Phase_Clock;
                    snap_d.vswing   = i_Voltage_swing;
                    neg_rate_d      = '0;
                    neg_clk_d       = '0;
                    neg_phase_d     = '0;
                    done_d          = 1'b0;
                    error_d         = 1'b0;
`ifdef PARAM_NEG_RETRY_EN
                    retry_d         = '0;
`endif
                    state_d         = S_SEND_REQ;
                end
            end
            S_SEND_REQ: begin
                if (i_tx_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_q + 1'b1;
                // A valid response beats a timeout in the same cycle.
                if (i_rx_valid && (i_rx_msgid == MSG_RSP)) begin
                    rsp_d   = i_rx_data[CAP_W-1:0];
                    state_d = S_RESOLVE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
`ifdef PARAM_NEG_RETRY_EN
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_SEND_REQ;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
`else
                    error_d = 1'b1;
                    state_d = S_ERROR;
`endif
                end
            end
            S_RESOLVE: begin
                if (res_fail) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    neg_rate_d  = res_rate;
                    neg_clk_d   = snap_q.clk_mode;
                    neg_phase_d = res_phase;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Request payload is driven only while a request is pending.
        tx_valid_d = (state_d == S_SEND_REQ);
        tx_msgid_d = tx_valid_d ? MSG_REQ : 2'b00;
        tx_data_d  = tx_valid_d ? DATA_W'(snap_d) : '0;
        busy_d     = (state_d == S_SEND_REQ) || (state_d == S_WAIT_RSP) || (state_d == S_RESOLVE);
    end

    assign o_tx_valid        = tx_valid_q;
    assign o_tx_msgid        = tx_msgid_q;
    assign o_tx_data         = tx_data_q;
    assign o_Neg_DataRate    = neg_rate_q;
    assign o_Neg_Clock_Mode  = neg_clk_q;
    assign o_Neg_Phase_Clock = neg_phase_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_error           = error_q;
endmodule

// File: tb/tb_mbinit_param_negotiator.sv
// Randomized bench for mbinit_param_negotiator against a transaction-level resolution model.
module tb_mbinit_param_negotiator;
    localparam int unsigned T_CYC = 40;
    localparam int unsigned C_W   = 6;
    localparam int unsigned M_RTY = 2;
`ifdef PARAM_NEG_RETRY_EN
    localparam int NRETRY = M_RTY;
`else
    localparam int NRETRY = 0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_Max_DataRate;
    logic [1:0]  i_Clock_Mode;
    logic [1:0]  i_Phase_Clock;
    logic [4:0]  i_Voltage_swing;
    logic        o_tx_valid;
    logic [1:0]  o_tx_msgid;
    logic [15:0] o_tx_data;
    logic        i_tx_ready;
    logic        i_rx_valid;
    logic [1:0]  i_rx_msgid;
    logic [15:0] i_rx_data;
    logic [2:0]  o_Neg_DataRate;
    logic [1:0]  o_Neg_Clock_Mode;
    logic [1:0]  o_Neg_Phase_Clock;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int n_cmp = 0;
    int n_bad = 0;
    int req_cnt = 0;

    mbinit_param_negotiator #(.TIMEOUT_CYC(T_CYC), .CNT_W(C_W), .MAX_RETRY(M_RTY)) dut (
        .CLK(CLK), .rst(rst), .i_start(i_start),
        .i_Max_DataRate(i_Max_DataRate), .i_Clock_Mode(i_Clock_Mode),
        .i_Phase_Clock(i_Phase_Clock), .i_Voltage_swing(i_Voltage_swing),
        .o_tx_valid(o_tx_valid), .o_tx_msgid(o_tx_msgid), .o_tx_data(o_tx_data),
        .i_tx_ready(i_tx_ready), .i_rx_valid(i_rx_valid), .i_rx_msgid(i_rx_msgid),
        .i_rx_data(i_rx_data), .o_Neg_DataRate(o_Neg_DataRate),
        .o_Neg_Clock_Mode(o_Neg_Clock_Mode), .o_Neg_Phase_Clock(o_Neg_Phase_Clock),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 CLK = ~CLK;

    // Counts every accepted request handshake on the sideband.
    always @(posedge CLK) if (o_tx_valid && i_tx_ready) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic scramble_inputs();
        i_Max_DataRate  = 3'($urandom);
        i_Clock_Mode    = 2'($urandom);
        i_Phase_Clock   = 2'($urandom);
        i_Voltage_swing = 5'($urandom);
    endtask

    function automatic logic [1:0] bogus_id();
        logic [1:0] m;
        m = 2'($urandom_range(0, 2));
        if (m == 2'b10) m = 2'b11;
        return m;
    endfunction

    // Reference: negotiated outcome from the two capability sets.
    function automatic void ref_resolve(input logic [2:0] lr, input logic [2:0] pr,
                                        input logic [1:0] lc, input logic [1:0] pc,
                                        input logic [1:0] lp, input logic [1:0] pp,
                                        output bit ok, output logic [2:0] r,
                                        output logic [1:0] c, output logic [1:0] p);
        int rmin;
        rmin = (int'(lr) < int'(pr)) ? int'(lr) : int'(pr);
        ok = (lr != 3'd0) && (pr != 3'd0) && (lc == pc) && ((lp & pp) != 2'b00);
        r  = ok ? 3'(rmin) : 3'd0;
        c  = ok ? lc : 2'd0;
        p  = ok ? (lp & pp) : 2'd0;
    endfunction

    task automatic run_neg(input logic [2:0] lr, input logic [1:0] lc, input logic [1:0] lp,
                           input logic [4:0] lv, input logic [2:0] pr, input logic [1:0] pc,
                           input logic [1:0] pp, input logic [4:0] pv,
                           input int stall, input int dly);
        logic [15:0] exp_tx;
        bit          ok;
        logic [2:0]  er;
        logic [1:0]  ec, ep;
        int          req0;
        exp_tx = {4'b0000, lv, lp, lc, lr};
        ref_resolve(lr, pr, lc, pc, lp, pp, ok, er, ec, ep);

        i_Max_DataRate = lr; i_Clock_Mode = lc; i_Phase_Clock = lp; i_Voltage_swing = lv;
        i_tx_ready = (stall == 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        scramble_inputs();
        req0 = req_cnt;
        chk("req_valid", 32'(o_tx_valid), 1);
        chk("req_msgid", 32'(o_tx_msgid), 1);
        chk("req_data", 32'(o_tx_data), 32'(exp_tx));
        chk("req_busy", 32'(o_busy), 1);
        chk("start_clr_done", 32'(o_done), 0);
        chk("start_clr_err", 32'(o_error), 0);

        for (int k = 0; k < stall; k++) begin
            i_rx_valid = 1'($urandom);
            i_rx_msgid = 2'b10;
            i_rx_data  = 16'($urandom);
            tick();
            chk("stall_valid", 32'(o_tx_valid), 1);
            chk("stall_data", 32'(o_tx_data), 32'(exp_tx));
        end
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'($urandom);
        chk("xfer_valid_drop", 32'(o_tx_valid), 0);
        chk("xfer_req_count", 32'(req_cnt - req0), 1);

        for (int k = 0; k < dly; k++) begin
            i_rx_valid = 1'($urandom);
            i_rx_msgid = bogus_id();
            i_rx_data  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        i_rx_valid = 1'b1;
        i_rx_msgid = 2'b10;
        i_rx_data  = {4'($urandom), pv, pp, pc, pr};
        tick();
        i_rx_valid = 1'b0;
        chk("resolve_busy", 32'(o_busy), 1);
        chk("resolve_done_early", 32'(o_done), 0);
        tick();
        chk("final_done", 32'(o_done), 32'(ok));
        chk("final_error", 32'(o_error), 32'(!ok));
        chk("neg_rate", 32'(o_Neg_DataRate), 32'(er));
        chk("neg_clk", 32'(o_Neg_Clock_Mode), 32'(ec));
        chk("neg_phase", 32'(o_Neg_Phase_Clock), 32'(ep));
        chk("final_busy", 32'(o_busy), 0);
        chk("single_req", 32'(req_cnt - req0), 1);

        // Late responses after completion are dropped; results hold.
        i_rx_valid = 1'b1;
        i_rx_msgid = 2'b10;
        i_rx_data  = 16'($urandom);
        tick();
        i_rx_valid = 1'b0;
        tick();
        chk("hold_done", 32'(o_done), 32'(ok));
        chk("hold_rate", 32'(o_Neg_DataRate), 32'(er));
        chk("hold_phase", 32'(o_Neg_Phase_Clock), 32'(ep));
    endtask

    task automatic run_timeout();
        int req0;
        i_Max_DataRate = 3'd4; i_Clock_Mode = 2'b00; i_Phase_Clock = 2'b11; i_Voltage_swing = 5'd9;
        i_tx_ready = 1'b1;
        i_start = 1'b1;
        req0 = req_cnt;
        tick();
        i_start = 1'b0;
        tick();
        for (int r = 0; r <= NRETRY; r++) begin
            for (int k = 0; k < int'(T_CYC) - 1; k++) begin
                i_rx_valid = 1'($urandom);
                i_rx_msgid = bogus_id();
                tick();
            end
            i_rx_valid = 1'b0;
            chk("to_not_yet", 32'(o_error), 0);
            tick();
            if (r < NRETRY) begin
                chk("retry_valid", 32'(o_tx_valid), 1);
                tick();
            end else begin
                chk("to_error", 32'(o_error), 1);
                chk("to_no_done", 32'(o_done), 0);
                chk("to_busy", 32'(o_busy), 0);
            end
        end
        chk("to_req_total", 32'(req_cnt - req0), 32'(NRETRY + 1));
        i_rx_valid = 1'b1;
        i_rx_msgid = 2'b10;
        i_rx_data  = 16'h0023;
        tick();
        i_rx_valid = 1'b0;
        tick();
        chk("err_sticky", 32'(o_error), 1);
        chk("err_late_rsp_done", 32'(o_done), 0);
        chk("err_neg_zero", 32'(o_Neg_DataRate), 0);
    endtask

    task automatic run_reset_abort();
        i_Max_DataRate = 3'd6; i_Clock_Mode = 2'b10; i_Phase_Clock = 2'b01; i_Voltage_swing = 5'd31;
        i_tx_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(o_tx_valid), 0);
        chk("rst_msgid", 32'(o_tx_msgid), 0);
        chk("rst_data", 32'(o_tx_data), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_error", 32'(o_error), 0);
        i_rx_valid = 1'b1;
        i_rx_msgid = 2'b10;
        i_rx_data  = {4'b0, 5'd0, 2'b01, 2'b10, 3'd5};
        tick();
        i_rx_valid = 1'b0;
        repeat (2) tick();
        chk("rst_late_done", 32'(o_done), 0);
        chk("rst_late_busy", 32'(o_busy), 0);
        chk("rst_late_rate", 32'(o_Neg_DataRate), 0);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_tx_ready = 1'b0; i_rx_valid = 1'b0;
        i_rx_msgid = 2'b00; i_rx_data = '0;
        i_Max_DataRate = '0; i_Clock_Mode = '0; i_Phase_Clock = '0; i_Voltage_swing = '0;
        repeat (2) tick();
        chk("reset_valid", 32'(o_tx_valid), 0);
        chk("reset_data", 32'(o_tx_data), 0);
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_done", 32'(o_done), 0);
        chk("reset_error", 32'(o_error), 0);
        chk("reset_rate", 32'(o_Neg_DataRate), 0);
        rst = 1'b0;
        tick();

        run_neg(3'd3, 2'b00, 2'b01, 5'd0, 3'd5, 2'b00, 2'b11, 5'd7, 0, 0);
        run_neg(3'd3, 2'b00, 2'b01, 5'd0, 3'd5, 2'b01, 2'b11, 5'd7, 0, 2);
        run_neg(3'd7, 2'b11, 2'b11, 5'd21, 3'd6, 2'b11, 2'b10, 5'd3, 5, 1);
        run_neg(3'd2, 2'b01, 2'b10, 5'd4, 3'd2, 2'b01, 2'b11, 5'd1, 1, int'(T_CYC) - 1);
        run_neg(3'd0, 2'b00, 2'b11, 5'd4, 3'd4, 2'b00, 2'b11, 5'd1, 0, 3);
        run_neg(3'd5, 2'b10, 2'b10, 5'd4, 3'd4, 2'b10, 2'b01, 5'd1, 0, 3);
        run_timeout();
        run_reset_abort();

        for (int it = 0; it < 40; it++) begin
            logic [2:0] lr, pr;
            logic [1:0] lc, pc;
            int d;
            lr = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            pr = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            lc = 2'($urandom);
            pc = ($urandom_range(0, 3) != 0) ? lc : 2'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? int'(T_CYC) - 1 : int'($urandom_range(0, 10));
            run_neg(lr, lc, 2'($urandom), 5'($urandom), pr, pc, 2'($urandom), 5'($urandom),
                    int'($urandom_range(0, 3)), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
